// File: rtl/dsp_accum_pkg.sv
// Shared constants for the accumulate-and-dump stage.
// Holds the default widths used by dsp_accum so that neighbouring dsp_*
// blocks and benches agree on the product/result stream sizes.
package dsp_accum_pkg;

  // Width of the signed product stream coming out of dsp_mult.
  localparam int DEF_INPUT_WIDTH  = 32;
  // Width of the signed block sum.
  localparam int DEF_OUTPUT_WIDTH = 48;
  // Width of the block-length control input.
  localparam int DEF_LENGTH_WIDTH = 16;

endpackage

// File: rtl/dsp_sat_add.sv
// Signed two's-complement adder with clamp to the representable range.
// Ports:
//   a, b  in   WIDTH  signed operands
//   sum   out  WIDTH  a+b clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//   ovf   out  1      1 when the true sum fell outside that range
module dsp_sat_add #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide;

  // One guard bit is enough: two WIDTH-bit signed values never overflow WIDTH+1.
  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  always_comb begin
    ovf = wide[WIDTH] ^ wide[WIDTH-1];
    sum = wide[WIDTH-1:0];
    if (ovf) begin
      // The guard bit holds the true sign of the sum.
      sum = wide[WIDTH] ? MIN_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/dsp_accum.sv
// Accumulate-and-dump stage: sums blocks of 'length' signed samples with
// saturation and emits one signed block sum per block over AXI-stream.
// Ports:
//   clk            in   1             clock, rising edge
//   rst            in   1             asynchronous reset, active low
//   length         in   LENGTH_WIDTH  samples per block (0 behaves as 1)
//   input_tdata    in   INPUT_WIDTH   signed sample
//   input_tvalid   in   1             sample valid
//   input_tready   out  1             sample accepted when valid & ready
//   output_tdata   out  OUTPUT_WIDTH  signed saturated block sum
//   output_tuser   out  1             saturation occurred within the block
//   output_tvalid  out  1             result valid
//   output_tready  in   1             downstream ready
// Handshake: a transfer happens on a rising edge where tvalid and tready are
// both high; a held result keeps tdata/tuser stable until it is taken.
module dsp_accum
  import dsp_accum_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LENGTH_WIDTH-1:0] length,
  input  logic [INPUT_WIDTH-1:0]  input_tdata,
  input  logic                    input_tvalid,
  output logic                    input_tready,
  output logic [OUTPUT_WIDTH-1:0] output_tdata,
  output logic                    output_tuser,
  output logic                    output_tvalid,
  input  logic                    output_tready
);

  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

  logic [LENGTH_WIDTH-1:0] count;
  logic [LENGTH_WIDTH-1:0] len_reg;
  logic [LENGTH_WIDTH-1:0] len_eff;
  logic [OUTPUT_WIDTH-1:0] acc;
  logic [OUTPUT_WIDTH-1:0] ext;
  logic [OUTPUT_WIDTH-1:0] base;
  logic [OUTPUT_WIDTH-1:0] sum;
  logic                    ovf;
  logic                    sat_flag;
  logic                    flag_now;
  logic                    count_zero;
  logic                    accept;
  logic                    last;

  // Any sample stalls while an untaken result is held: there is nowhere to
  // put a second result, so we refuse input rather than track it.
  assign input_tready = rst & (~output_tvalid | output_tready);
  assign accept       = input_tvalid & input_tready;
  assign count_zero   = (count == '0);

  // First sample of a block reads 'length' live; later samples use the copy.
  assign len_eff  = count_zero ? ((length == '0) ? LEN_ONE : length) : len_reg;
  assign last     = accept & (count == (len_eff - LEN_ONE));

  assign ext      = OUTPUT_WIDTH'($signed(input_tdata));
  assign base     = count_zero ? '0 : acc;
  assign flag_now = (~count_zero & sat_flag) | ovf;

  dsp_sat_add #(
    .WIDTH (OUTPUT_WIDTH)
  ) u_sat_add (
    .a   (base),
    .b   (ext),
    .sum (sum),
    .ovf (ovf)
  );

  // Block accumulator and sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      count    <= '0;
      len_reg  <= '0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc      <= sum;
      sat_flag <= flag_now;
      if (count_zero) begin
        len_reg <= len_eff;
      end
      count <= last ? '0 : (count + LEN_ONE);
    end
  end

  // Result register: a completing block overwrites a result that is being
  // taken in the same cycle, so length-1 blocks stream at one per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tdata  <= '0;
      output_tuser  <= 1'b0;
      output_tvalid <= 1'b0;
    end else if (last) begin
      output_tdata  <= sum;
      output_tuser  <= flag_now;
      output_tvalid <= 1'b1;
    end else if (output_tready) begin
      output_tvalid <= 1'b0;
    end
  end

endmodule
